// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the
// boot loader.
//   rx_data/rx_valid/rx_ready : UART receive stream (valid/ready)
//   we/waddr/wdata            : instruction-memory write port
// Modports: master = loader side, slave = UART/memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, we, waddr, wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Parses MAGIC, LEN_LO, LEN_HI,
// 4*N little-endian data bytes and an XOR checksum from the byte stream,
// writes each word into instruction memory, and holds the core in reset
// until a checksum-verified image is stored.
//   clk, rst_n : system clock, async active-low reset
//   bus        : rx stream in, instruction-memory write port out
//   cpu_rst_n  : core reset, released only while a valid image is loaded
//   busy       : load in progress (LEN0..CSUM)
//   done       : valid image loaded
//   err        : last load failed (sticky until next MAGIC)
//
// state | meaning
// IDLE  | waiting for MAGIC after reset
// LEN0  | expecting word-count low byte
// LEN1  | expecting word-count high byte; bounds check
// DATA  | assembling and writing words
// CSUM  | expecting checksum byte
// DONE  | image valid, core released
// ERR   | load rejected, core held
module imem_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  imem_loader_if.master      bus,
  output logic               cpu_rst_n,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  localparam int unsigned       CAP   = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t            state, state_nxt;
  logic              rx_ready_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_d, done_d, err_d;

  logic [15:0]       len_q;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        byte_idx;
  logic [31:0]       asm_q;
  logic [7:0]        csum_q;

  logic              acc;
  logic [15:0]       len_in;
  logic [31:0]       asm_nxt;
  logic              last_word;

  assign acc       = bus.rx_valid && rx_ready_q;
  assign len_in    = {bus.rx_data, len_q[7:0]};
  // Little-endian: bytes enter at the top and shift down, so the first byte
  // of a word ends up in [7:0] after four shifts.
  assign asm_nxt   = {bus.rx_data, asm_q[31:8]};
  assign last_word = (32'(word_addr) + 32'd1) == 32'(len_q);

  assign bus.rx_ready = rx_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst_n  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rx_ready_q <= 1'b1;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      cpu_rst_n  <= done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    if (acc) begin
      case (state)
        IDLE, DONE, ERR: if (bus.rx_data == MAGIC) state_nxt = LEN0;
        LEN0:            state_nxt = LEN1;
        LEN1: begin
          if (32'(len_in) > CAP)  state_nxt = ERR;
          else if (len_in == '0)  state_nxt = CSUM;
          else                    state_nxt = DATA;
        end
        DATA:            if (byte_idx == 2'd3 && last_word) state_nxt = CSUM;
        CSUM:            state_nxt = (bus.rx_data == csum_q) ? DONE : ERR;
        default:         state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    we_d    = acc && (state == DATA) && (byte_idx == 2'd3);
    waddr_d = we_d ? word_addr : waddr_q;
    wdata_d = we_d ? asm_nxt : wdata_q;
    busy_d  = state_nxt inside {LEN0, LEN1, DATA, CSUM};
    done_d  = state_nxt == DONE;
    err_d   = state_nxt == ERR;
  end

  // Load datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      word_addr <= '0;
      byte_idx  <= '0;
      asm_q     <= '0;
      csum_q    <= '0;
    end else if (acc) begin
      case (state)
        IDLE, DONE, ERR: if (bus.rx_data == MAGIC) csum_q <= '0;
        LEN0: len_q[7:0] <= bus.rx_data;
        LEN1: begin
          len_q[15:8] <= bus.rx_data;
          word_addr   <= '0;
          byte_idx    <= '0;
          csum_q      <= '0;
        end
        DATA: begin
          asm_q    <= asm_nxt;
          csum_q   <= csum_q ^ bus.rx_data;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) word_addr <= word_addr + ONE_A;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int         ADDR_W = 8;
  localparam logic [7:0] MAGIC  = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_rst_n, busy, done, err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int we_cnt = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        img[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write-port scoreboard
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      logic [ADDR_W+31:0] e;
      we_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_we: observed addr %h data %h expected no write", bus.waddr, bus.wdata);
      end else begin
        e = exp_q.pop_front();
        assert ({bus.waddr, bus.wdata} === e) else begin
          fails++;
          $error("FAIL write: observed %h/%h expected %h/%h",
                 bus.waddr, bus.wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    if (gap) begin
      bus.rx_data = ~b;
      @(posedge clk);
      #1;
    end
  endtask

  // Sends MAGIC, length, all words of img, and checksum (corrupted if bad)
  task automatic do_load(input bit bad, input bit gap);
    int         n;
    logic [7:0] x;
    logic [7:0] by;
    n = img.size();
    x = 8'h00;
    send(MAGIC, gap);
    check("magic_busy", 32'(busy), 32'd1);
    check("magic_done", 32'(done), 32'd0);
    check("magic_err", 32'(err), 32'd0);
    check("magic_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    send(n[7:0], gap);
    send(n[15:8], gap);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        by = img[i][8*b +: 8];
        x  = x ^ by;
        if (b == 3) exp_q.push_back({i[ADDR_W-1:0], img[i]});
        send(by, gap);
      end
    end
    check("pre_csum_busy", 32'(busy), 32'd1);
    send(bad ? (x ^ 8'h01) : x, 1'b0);
    check("end_done", 32'(done), bad ? 32'd0 : 32'd1);
    check("end_cpu_rst_n", 32'(cpu_rst_n), bad ? 32'd0 : 32'd1);
    check("end_err", 32'(err), bad ? 32'd1 : 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(bus.we), 32'd0);
    check({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
    check({tag, "_wdata"}, bus.wdata, 32'd0);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    rst_n        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("release_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("release_done", 32'(done), 32'd0);

    // Garbage in IDLE
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h5A, 1'b0);
    check("garbage_busy", 32'(busy), 32'd0);
    check("garbage_done", 32'(done), 32'd0);
    check("garbage_err", 32'(err), 32'd0);
    check("garbage_we_cnt", 32'(we_cnt), 32'd0);

    // Good 2-word load
    img = '{32'h00000013, 32'h00100093};
    do_load(1'b0, 1'b0);
    check("good2_we_cnt", 32'(we_cnt), 32'd2);

    // Bad checksum, then a good 1-word load clears err
    do_load(1'b1, 1'b0);
    check("bad_we_cnt", 32'(we_cnt), 32'd4);
    img = '{32'hDEADBEEF};
    do_load(1'b0, 1'b0);

    // Oversize N=257
    w0 = we_cnt;
    send(MAGIC, 1'b0);
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    check("oversize_err", 32'(err), 32'd1);
    check("oversize_busy", 32'(busy), 32'd0);
    check("oversize_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    send(8'h00, 1'b0);
    send(8'h11, 1'b0);
    check("oversize_ignored_err", 32'(err), 32'd1);
    check("oversize_no_we", 32'(we_cnt), 32'(w0));

    // Zero-length
    img = {};
    w0 = we_cnt;
    do_load(1'b0, 1'b0);
    check("zero_no_we", 32'(we_cnt), 32'(w0));

    // Throttled 1-word load
    img = '{32'hCAFE1234};
    w0 = we_cnt;
    do_load(1'b0, 1'b1);
    check("throttle_we_cnt", 32'(we_cnt), 32'(w0 + 1));

    // Full-capacity load N=256: last word at 255, no wrap
    img = {};
    for (int i = 0; i < 256; i++) img.push_back($urandom);
    w0 = we_cnt;
    do_load(1'b0, 1'b0);
    check("full_we_cnt", 32'(we_cnt), 32'(w0 + 256));

    // Reset mid-load after 6 data bytes
    send(MAGIC, 1'b0);
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    exp_q.push_back({8'h00, 32'h44332211});
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    check("midload_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_q_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    img = '{32'h76543210, 32'h89ABCDEF};
    do_load(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
